lock_keyer: RTL and testbench

Automatic code sender for the `lock` combination lock: it drives the lock's `b0`/`b1`/`enter` pulse inputs from a stored key and reads back the lock's `out` (locked) flag. It has two modes. Single mode presents one key. Sweep mode brute-forces upward from a starting key until the lock opens or the code space is exhausted. It sits beside `lock` in bench and board top levels, in place of the debounced button pulses.

---
 rtl/lock_keyer.sv | 155 +++++++++++++++
 tb/tb_lock_keyer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lock_keyer.sv
// lock_keyer: drives a combination lock's b0/b1/enter pulses from a stored
// key, either once (single mode) or counting upward until the lock opens or
// the key reaches all ones (sweep mode).
module lock_keyer #(
   parameter int CODE_SIZE = 8,
   parameter int GAP       = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 sweep,
   input  logic [CODE_SIZE-1:0] key,
   input  logic                 locked,
   output logic                 b0,
   output logic                 b1,
   output logic                 enter,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic [CODE_SIZE-1:0] candidate,
   output logic [CODE_SIZE:0]   attempts
);

   localparam int IDX_W = (CODE_SIZE > 1) ? $clog2(CODE_SIZE) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_GAP, S_ENTER, S_CHECK, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 mode_q, mode_d;
   logic [CODE_SIZE-1:0] cand_q, cand_d;
   logic                 found_q, found_d;
   logic [CODE_SIZE:0]   att_q, att_d;
   logic                 b0_q, b0_d, b1_q, b1_d, enter_q, enter_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic                 bit_end;
   logic [IDX_W-1:0]     bit_sel;

   // Next-state and datapath; pulse outputs are decoded from the next state
   // so that the registered pulse appears in the same cycle as its state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      mode_d  = mode_q;
      cand_d  = cand_q;
      found_d = found_q;
      att_d   = att_q;
      bit_end = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT;
               cand_d  = key;
               mode_d  = sweep;
               found_d = 1'b0;
               att_d   = '0;
               idx_d   = '0;
            end
         end
         S_SHIFT: begin
            if (GAP > 0) begin
               state_d = S_GAP;
               gap_d   = GAP_W'(GAP - 1);
            end else begin
               bit_end = 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == '0) bit_end = 1'b1;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         S_ENTER: state_d = S_CHECK;
         S_CHECK: begin
            if (!locked) begin
               found_d = 1'b1;
               state_d = S_DONE;
            end else if (!mode_q || (&cand_q)) begin
               state_d = S_DONE;
            end else begin
               cand_d  = cand_q + CODE_SIZE'(1);
               idx_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // End of a bit slot: either the next bit or the enter pulse
      if (bit_end) begin
         if (idx_q == IDX_W'(CODE_SIZE - 1)) begin
            state_d = S_ENTER;
            att_d   = att_q + (CODE_SIZE+1)'(1);
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SHIFT;
         end
      end

      // MSB first: bit index 0 selects the top bit of the candidate
      bit_sel = IDX_W'(CODE_SIZE - 1) - idx_d;
      b1_d    = (state_d == S_SHIFT) &&  cand_d[bit_sel];
      b0_d    = (state_d == S_SHIFT) && !cand_d[bit_sel];
      enter_d = (state_d == S_ENTER);
      busy_d  = (state_d == S_SHIFT) || (state_d == S_GAP) ||
                (state_d == S_ENTER) || (state_d == S_CHECK);
      done_d  = (state_d == S_DONE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         mode_q  <= 1'b0;
         cand_q  <= '0;
         found_q <= 1'b0;
         att_q   <= '0;
         b0_q    <= 1'b0;
         b1_q    <= 1'b0;
         enter_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         mode_q  <= mode_d;
         cand_q  <= cand_d;
         found_q <= found_d;
         att_q   <= att_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         enter_q <= enter_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign b0        = b0_q;
   assign b1        = b1_q;
   assign enter     = enter_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign found     = found_q;
   assign candidate = cand_q;
   assign attempts  = att_q;

endmodule

// File: tb/tb_lock_keyer.sv
// Bench for lock_keyer: two instances (10-bit/GAP=1 and 4-bit/GAP=0), each
// attached to a behavioural lock. Expected pulse timelines are built from the
// attempt-schedule arithmetic and compared cycle by cycle.
module tb_lock_keyer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, lk_rst, sweep;
   logic start10, start4;
   logic [9:0] key10;
   logic [3:0] key4;
   logic locked10, locked4;
   logic b0_10, b1_10, en_10, busy10, done10, found10;
   logic b0_4, b1_4, en_4, busy4, done4, found4;
   logic [9:0]  cand10;
   logic [10:0] att10;
   logic [3:0]  cand4;
   logic [4:0]  att4;

   lock_keyer #(.CODE_SIZE(10), .GAP(1)) u10 (
      .clk(clk), .reset_n(reset_n), .start(start10), .sweep(sweep), .key(key10),
      .locked(locked10), .b0(b0_10), .b1(b1_10), .enter(en_10), .busy(busy10),
      .done(done10), .found(found10), .candidate(cand10), .attempts(att10));

   lock_keyer #(.CODE_SIZE(4), .GAP(0)) u4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .sweep(sweep), .key(key4),
      .locked(locked4), .b0(b0_4), .b1(b1_4), .enter(en_4), .busy(busy4),
      .done(done4), .found(found4), .candidate(cand4), .attempts(att4));

   // Behavioural locks: shift in bits, compare on enter, out=1 means locked
   logic [9:0] lk10_sr, lk10_code;
   logic [3:0] lk4_sr, lk4_code;
   always @(posedge clk) begin
      if (lk_rst) begin
         lk10_sr <= '0; locked10 <= 1'b1;
         lk4_sr  <= '0; locked4  <= 1'b1;
      end else begin
         if (b0_10)      lk10_sr <= {lk10_sr[8:0], 1'b0};
         else if (b1_10) lk10_sr <= {lk10_sr[8:0], 1'b1};
         if (en_10)      locked10 <= (lk10_sr != lk10_code);
         if (b0_4)       lk4_sr <= {lk4_sr[2:0], 1'b0};
         else if (b1_4)  lk4_sr <= {lk4_sr[2:0], 1'b1};
         if (en_4)       locked4 <= (lk4_sr != lk4_code);
      end
   end

   // Monitor mux onto whichever instance is under test
   logic        sel;
   logic [2:0]  m_pulse;
   logic        m_busy, m_done, m_found, m_lock;
   logic [9:0]  m_cand;
   logic [10:0] m_att;
   assign m_pulse = sel ? {en_4, b1_4, b0_4} : {en_10, b1_10, b0_10};
   assign m_busy  = sel ? busy4  : busy10;
   assign m_done  = sel ? done4  : done10;
   assign m_found = sel ? found4 : found10;
   assign m_lock  = sel ? locked4 : locked10;
   assign m_cand  = sel ? {6'd0, cand4} : cand10;
   assign m_att   = sel ? {6'd0, att4}  : att10;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One run: build the expected timeline from key/code arithmetic, then
   // watch the DUT cycle by cycle. glitch = cycle of an extra start pulse,
   // rst_at = cycle in which reset_n is pulled low (-1 = unused).
   task automatic run(input bit s4, input int key_i, input bit sw,
                      input int glitch, input int rst_at);
      int ep[int];
      int cs, gap, a_len, code, maxk, n, c, dcyc, last, ep_v;
      bit e_found, dead;
      cs    = s4 ? 4 : 10;
      gap   = s4 ? 0 : 1;
      code  = s4 ? int'(lk4_code) : int'(lk10_code);
      maxk  = (1 << cs) - 1;
      a_len = cs * (1 + gap) + 2;
      n = 0; c = key_i; e_found = 0;
      forever begin
         for (int i = 0; i < cs; i++)
            ep[n*a_len + i*(1+gap)] = ((c >> (cs-1-i)) & 1) ? 2 : 1;
         ep[n*a_len + cs*(1+gap)] = 4;
         if (c == code) begin e_found = 1; break; end
         if (!sw || c == maxk) break;
         c++; n++;
      end
      dcyc = (n + 1) * a_len;
      last = (rst_at >= 0) ? rst_at + 6 : dcyc;
      sel  = s4;
      @(posedge clk); #1;
      sweep = sw;
      if (s4) begin start4 = 1'b1; key4 = 4'(key_i); end
      else    begin start10 = 1'b1; key10 = 10'(key_i); end
      @(posedge clk); #1;
      for (int cy = 0; cy <= last; cy++) begin
         if (s4) start4 = (cy == glitch); else start10 = (cy == glitch);
         reset_n = !(rst_at >= 0 && cy >= rst_at && cy < rst_at + 3);
         key10 = 10'($urandom); key4 = 4'($urandom); sweep = 1'($urandom);
         @(negedge clk);
         dead = (rst_at >= 0) && (cy > rst_at);
         ep_v = (!dead && ep.exists(cy)) ? ep[cy] : 0;
         chk("pulse", 32'(m_pulse), 32'(ep_v));
         chk("busy", 32'(m_busy), 32'(!dead && cy < dcyc));
         chk("done", 32'(m_done), 32'(!dead && cy == dcyc));
         if (dead && cy == last) begin
            chk("rst_found", 32'(m_found), 0);
            chk("rst_cand", 32'(m_cand), 0);
            chk("rst_att", 32'(m_att), 0);
         end
         if (!dead && cy == dcyc) begin
            chk("found", 32'(m_found), 32'(e_found));
            chk("candidate", 32'(m_cand), 32'(c));
            chk("attempts", 32'(m_att), 32'(n + 1));
            chk("lock_out", 32'(m_lock), 32'(!e_found));
         end
         @(posedge clk); #1;
      end
      start10 = 1'b0; start4 = 1'b0; reset_n = 1'b1;
   endtask

   initial begin
      int k, cd;
      bit sw;
      reset_n = 1'b0; lk_rst = 1'b1; sweep = 1'b0; sel = 1'b0;
      start10 = 1'b0; start4 = 1'b0; key10 = '0; key4 = '0;
      lk10_code = 10'b1000000110; lk4_code = 4'b1011;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out10", {26'd0, b0_10, b1_10, en_10, busy10, done10, found10}, 0);
      chk("reset_cand10", {22'd0, cand10}, 0);
      chk("reset_att10", {21'd0, att10}, 0);
      chk("reset_out4", {26'd0, b0_4, b1_4, en_4, busy4, done4, found4}, 0);
      chk("reset_ca4", {23'd0, cand4, att4}, 0);
      @(posedge clk); #1;
      reset_n = 1'b1; lk_rst = 1'b0;

      // Directed plan for the 10-bit instance
      run(0, 10'b1000000110, 0, -1, -1);
      run(0, 0, 0, -1, -1);
      run(0, 10'b1000000100, 1, -1, -1);
      lk10_code = '0;
      run(0, 10'b1111111110, 1, -1, -1);
      lk10_code = 10'b1000000110;
      run(0, 10'b1000000110, 0, 5, 9);
      run(0, 10'b1000000110, 0, -1, -1);
      // 4-bit, GAP=0 instance
      run(1, 4'b1011, 0, -1, -1);

      // Randomized runs on both instances
      repeat (8) begin
         cd = int'($urandom_range(0, 1023));
         lk10_code = 10'(cd);
         sw = 1'($urandom);
         case ($urandom_range(0, 2))
            0:       k = (cd > 4) ? cd - int'($urandom_range(0, 4)) : 0;
            1:       k = 1023 - int'($urandom_range(0, 3));
            default: k = int'($urandom_range(0, 1023));
         endcase
         run(0, k, sw, -1, -1);
      end
      repeat (8) begin
         lk4_code = 4'($urandom);
         run(1, int'($urandom_range(0, 15)), 1'($urandom), -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
